// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller with SCAN scheduling: latches floor calls, sweeps
// in one direction while calls remain ahead, times travel and door dwell.

module elevator_req_cell (
  input  logic clk,
  input  logic reset,
  input  logic call,
  input  logic block,
  input  logic clear,
  output logic pend
);
  // clear dominates so a call arriving as the door opens is absorbed by it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= 1'b0;
    else       pend <= (pend | (call & ~block)) & ~clear;
  end
endmodule

module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 6,
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES   = 4,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  door_close_req,
  input  logic                  hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LOAD = TRAVEL_W'(TRAVEL_CYCLES - 1);
  localparam logic [DOOR_W-1:0]   DOOR_LOAD   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  state_t                state, state_nxt;
  logic [TRAVEL_W-1:0]   travel_tmr, travel_nxt;
  logic [DOOR_W-1:0]     door_tmr, door_nxt;
  logic [FLOOR_W-1:0]    floor_nxt, step_floor;
  logic                  dir_nxt, at_bound;
  logic [NUM_FLOORS-1:0] clear_mask, cur_onehot;
  logic                  above, below, step_above, step_below;

  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  // Per-floor request latches; the current floor is blocked while its door is open
  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    elevator_req_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .call  (call_req[i]),
      .block (door_open & cur_onehot[i]),
      .clear (clear_mask[i]),
      .pend  (pending[i])
    );
  end

  always_comb begin
    cur_onehot = NUM_FLOORS'(1) << current_floor;
    above      = |(pending & above_mask(current_floor));
    below      = |(pending & below_mask(current_floor));
    step_floor = dir_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
    at_bound   = dir_up ? (current_floor == TOP_FLOOR) : (current_floor == '0);
    step_above = |(pending & above_mask(step_floor));
    step_below = |(pending & below_mask(step_floor));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      travel_tmr    <= '0;
      door_tmr      <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
    end else begin
      state         <= state_nxt;
      travel_tmr    <= travel_nxt;
      door_tmr      <= door_nxt;
      current_floor <= floor_nxt;
      dir_up        <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    travel_nxt = travel_tmr;
    door_nxt   = door_tmr;
    floor_nxt  = current_floor;
    dir_nxt    = dir_up;
    clear_mask = '0;
    unique case (state)
      IDLE: begin
        if (pending[current_floor]) begin
          state_nxt  = DOOR_OPEN;
          clear_mask = cur_onehot;
          door_nxt   = DOOR_LOAD;
        end else if (dir_up && above) begin
          state_nxt  = MOVING;
          travel_nxt = TRAVEL_LOAD;
        end else if (dir_up && below) begin
          state_nxt  = MOVING;
          dir_nxt    = 1'b0;
          travel_nxt = TRAVEL_LOAD;
        end else if (!dir_up && below) begin
          state_nxt  = MOVING;
          travel_nxt = TRAVEL_LOAD;
        end else if (!dir_up && above) begin
          state_nxt  = MOVING;
          dir_nxt    = 1'b1;
          travel_nxt = TRAVEL_LOAD;
        end
      end
      MOVING: begin
        if (!hold) begin
          if (travel_tmr != '0) begin
            travel_nxt = travel_tmr - TRAVEL_W'(1);
          end else if (at_bound) begin
            state_nxt = IDLE;
          end else begin
            floor_nxt = step_floor;
            if (pending[step_floor]) begin
              state_nxt  = DOOR_OPEN;
              clear_mask = NUM_FLOORS'(1) << step_floor;
              door_nxt   = DOOR_LOAD;
            end else if (dir_up ? step_above : step_below) begin
              travel_nxt = TRAVEL_LOAD;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      DOOR_OPEN: begin
        // a call at this floor restarts the dwell and overrides an early close
        if (call_req[current_floor]) begin
          door_nxt = DOOR_LOAD;
        end else if (!hold) begin
          if (door_close_req || door_tmr == '0) state_nxt = IDLE;
          else                                  door_nxt  = door_tmr - DOOR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    moving    = (state == MOVING);
    door_open = (state == DOOR_OPEN);
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised N-floor elevator controller. It latches floor requests, schedules them in SCAN order (keep going in the current direction while requests remain ahead, then reverse), times floor-to-floor travel and door dwell, and reports position and status.
- Successor to the fixed 6-floor request/control pair. Adds a pending-request queue, early door close and a service hold.
- Sits between the synchronised switch/key inputs and the HEX/LED display logic on the divided clock.

Parameters:
- NUM_FLOORS, 6, number of floors (2..16).
- TRAVEL_CYCLES, 3, clocks to move one floor (>=1).
- DOOR_CYCLES, 4, clocks the door stays open (>=1).
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index (derived; do not override).

Ports:
- clk  in  1  system clock (divided clock in the top level).
- reset  in  1  asynchronous, active-high reset.
- call_req  in  NUM_FLOORS  per-floor request, level or pulse; sampled every clk.
- door_close_req  in  1  early door close, already synchronised.
- hold  in  1  service hold; freezes the travel and door timers.
- current_floor  out  FLOOR_W  current floor, 0 = ground.
- dir_up  out  1  scan direction, 1 = up.
- moving  out  1  high while in MOVING.
- door_open  out  1  high while in DOOR_OPEN.
- pending  out  NUM_FLOORS  latched, not-yet-served requests.

Behaviour:
- Interface: one clock, clk. reset is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - current_floor = 0, dir_up = 1, moving = 0, door_open = 0.
  - pending = 0, both timers = 0.
- Pending register:
  - Each clk: pending <= (pending | call_req) & ~clear_mask.
  - clear_mask is the one-hot of the floor whose door opens on that edge.
  - A call_req bit set on that same edge for that same floor is dropped (absorbed by the opening).
  - While in DOOR_OPEN, call_req[current_floor] is never latched. Instead it reloads the door timer.
- FSM states: IDLE, MOVING, DOOR_OPEN. All decisions use the registered pending value.
  - Define above = OR of pending bits above current_floor, below = OR of pending bits below it.
- IDLE, in priority order:
  1. pending[current_floor] -> DOOR_OPEN; clear that bit; door timer = DOOR_CYCLES-1.
  2. dir_up and above -> MOVING up.
  3. dir_up and below -> dir_up <= 0, MOVING down.
  4. !dir_up and below -> MOVING down.
  5. !dir_up and above -> dir_up <= 1, MOVING up.
  6. Otherwise stay in IDLE.
  - Entering MOVING loads travel timer = TRAVEL_CYCLES-1.
- MOVING:
  - While timer != 0 and !hold: decrement.
  - When timer == 0 and !hold: current_floor steps ±1 per dir_up on that edge. Let F be the new floor:
    - pending[F] -> DOOR_OPEN; clear bit F; load door timer.
    - Else requests remain beyond F in dir_up -> stay in MOVING; reload travel timer.
    - Else -> IDLE.
  - current_floor never leaves 0..NUM_FLOORS-1. A step past a bound is suppressed and the FSM goes to IDLE.
- DOOR_OPEN:
  - door_open is high for exactly DOOR_CYCLES clocks unless modified by the rules below.
  - Timer decrements when !hold. At timer == 0 and !hold -> IDLE.
  - door_close_req with !hold -> IDLE on the next edge.
  - call_req[current_floor] reloads the timer to DOOR_CYCLES-1. It wins over door_close_req.
  - hold wins over door_close_req: the door stays open.
- Latency: request at a remote floor, controller idle:
  - call_req sampled at edge E0; MOVING from E1.
  - Each floor takes TRAVEL_CYCLES edges.
  - door_open rises on the edge that current_floor reaches the target.
- hold in IDLE has no effect; departures still occur.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). Pending requests are discarded.

Test Plan:
(defaults NUM_FLOORS=6, TRAVEL_CYCLES=3, DOOR_CYCLES=4)
- Reset, then call_req=6'b000001 for 1 clk at floor 0 -> pending[0]=1 after E0; door_open=1 from E1 for exactly 4 clks; pending=0; back to IDLE.
- From IDLE at floor 0, call_req[3] pulse at E0 -> moving=1 from E1; current_floor=1 at E4, 2 at E7, 3 at E10 with door_open=1 and moving=0; pending[3] cleared.
- Going up, stopped at floor 3, with pending[1] and pending[5] -> serves 5 first (dir_up stays 1), then dir_up=0 and serves 1; floor 4 is passed without a stop.
- Door open at floor 2: door_close_req for 1 clk -> door_open=0 on the next edge. Repeat with call_req[2] in the same clk -> door stays open for 4 more clks.
- hold=1 for 5 clks in mid-travel -> current_floor and the travel timer freeze; arrival is delayed by exactly 5 clks. hold during DOOR_OPEN together with door_close_req -> door stays open.
- reset asserted while MOVING at floor 4 with pending[5] -> asynchronously current_floor=0, pending=0, moving=0, dir_up=1; no movement after release.
